// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache types for the line/burst adaptor: default widths, line and
// address typedefs, the adaptor state enum and the line-alignment helper.
package cacheline_adaptor_pkg;

   localparam int LINE_W_DEF  = 256;
   localparam int BURST_W_DEF = 64;
   localparam int ADDR_W      = 32;

   typedef logic [LINE_W_DEF-1:0] line_t;
   typedef logic [ADDR_W-1:0]     addr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Clears the byte-offset bits of a line (5 bits for a 256-bit line).
   function automatic addr_t line_base(input addr_t a, input int line_w);
      return a & ~addr_t'((line_w / 8) - 1);
   endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the adaptor. The slave modport is the
// adaptor's view; master is the view of whatever drives cache and memory.
interface cacheline_adaptor_if
   import cacheline_adaptor_pkg::*;
#(
   parameter int LINE_W  = LINE_W_DEF,
   parameter int BURST_W = BURST_W_DEF
);

   logic [LINE_W-1:0]  line_i;
   logic [LINE_W-1:0]  line_o;
   addr_t              address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   addr_t              address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   // Handshake: a request is taken when read_i/write_i is high in IDLE; every
   // cycle with resp_i high during a burst moves exactly one beat; resp_o is a
   // single-cycle completion pulse with no back-pressure.
   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts whole-cacheline read/write requests into NBEATS-beat memory bursts
// and reassembles read beats into a line.
module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
#(
   parameter int LINE_W  = LINE_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   cacheline_adaptor_if.slave     bus,
   output state_e                 state
);

   localparam int NBEATS = LINE_W / BURST_W;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   state_e             state_q;
   state_e             state_d;
   logic [CNT_W-1:0]   cnt;
   addr_t              addr_q;
   logic [LINE_W-1:0]  wbuf;
   logic [LINE_W-1:0]  rbuf;
   logic               beat;
   logic               last;

   // resp_i only counts while a burst is in flight; IDLE/DONE strobes are dropped.
   assign beat  = bus.resp_i && (state_q == ST_READ || state_q == ST_WRITE);
   assign last  = beat && (cnt == CNT_W'(NBEATS - 1));
   assign state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.write_i)     state_d = ST_WRITE;
            else if (bus.read_i) state_d = ST_READ;
         end
         ST_READ, ST_WRITE: if (last) state_d = ST_DONE;
         ST_DONE:           state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         addr_q <= '0;
         wbuf   <= '0;
         rbuf   <= '0;
      end else begin
         if (state_q == ST_IDLE) begin
            cnt <= '0;
            if (bus.write_i) begin
               addr_q <= line_base(bus.address_i, LINE_W);
               wbuf   <= bus.line_i;
            end else if (bus.read_i) begin
               addr_q <= line_base(bus.address_i, LINE_W);
            end
         end
         if (beat) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (state_q == ST_READ) rbuf[cnt*BURST_W +: BURST_W] <= bus.burst_i;
         end
      end
   end

   always_comb begin
      bus.read_o    = (state_q == ST_READ);
      bus.write_o   = (state_q == ST_WRITE);
      bus.resp_o    = (state_q == ST_DONE);
      bus.address_o = addr_q;
      bus.line_o    = rbuf;
      bus.burst_o   = '0;
      if (state_q == ST_WRITE) bus.burst_o = wbuf[cnt*BURST_W +: BURST_W];
   end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized line read/write transactions against a queue-based
// model of the adaptor's beat ordering, stalls, completion pulse and reset.
module tb_cacheline_adaptor;
   import cacheline_adaptor_pkg::*;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int NBEATS  = LINE_W / BURST_W;
   localparam int GUARD   = 64;

   logic   clk = 1'b0;
   logic   rst_n;
   state_e state;

   int n_checks = 0;
   int n_errors = 0;

   logic [BURST_W-1:0] exp_q[$];
   logic [BURST_W-1:0] beat_q[$];
   bit                 pat_q[$];
   logic [LINE_W-1:0]  line_model;

   always #5 clk = ~clk;

   cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W)) bus ();

   cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .state (state)
   );

   task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] aligned(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   function automatic logic [BURST_W-1:0] rnd_beat();
      return {$urandom, $urandom};
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_read_o"},  bus.read_o,  1'b0);
      check({tag, "_write_o"}, bus.write_o, 1'b0);
      check({tag, "_resp_o"},  bus.resp_o,  1'b0);
      check({tag, "_burst_o"}, bus.burst_o, '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_quiet(tag);
      check({tag, "_address_o"}, bus.address_o, '0);
      check({tag, "_line_o"},    bus.line_o,    '0);
      check({tag, "_state"},     state,         ST_IDLE);
   endtask

   function automatic bit next_resp(input bit rand_gaps);
      if (pat_q.size() > 0) return pat_q.pop_front();
      if (rand_gaps)        return ($urandom_range(0, 2) != 0);
      return 1'b1;
   endfunction

   // Expects the DUT in IDLE; beat_q holds the NBEATS beats memory returns.
   task automatic run_read(input logic [31:0] addr, input bit hold, input bit rand_gaps);
      logic [LINE_W-1:0] exp_line;
      int guard;
      bit r;
      exp_line = '0;
      for (int k = 0; k < NBEATS; k++)
         exp_line = exp_line | (LINE_W'(beat_q[k]) << (k * BURST_W));
      bus.address_i = addr;
      bus.read_i    = 1'b1;
      bus.write_i   = 1'b0;
      bus.resp_i    = 1'b0;
      step();
      if (!hold) bus.read_i = 1'b0;
      bus.address_i = $urandom;
      guard = 0;
      while (beat_q.size() > 0 && guard < GUARD) begin
         r = next_resp(rand_gaps);
         bus.resp_i  = r;
         bus.burst_i = r ? beat_q[0] : rnd_beat();
         check("rd_read_o",    bus.read_o,    1'b1);
         check("rd_write_o",   bus.write_o,   1'b0);
         check("rd_resp_o",    bus.resp_o,    1'b0);
         check("rd_address_o", bus.address_o, aligned(addr));
         step();
         guard++;
         if (r) void'(beat_q.pop_front());
      end
      bus.resp_i  = 1'b1;
      bus.burst_i = rnd_beat();
      check("rd_done_resp_o", bus.resp_o,  1'b1);
      check("rd_done_read_o", bus.read_o,  1'b0);
      check("rd_done_line_o", bus.line_o,  exp_line);
      line_model = exp_line;
      step();
      bus.resp_i = 1'b0;
      check("rd_after_resp_o", bus.resp_o, 1'b0);
      check("rd_after_read_o", bus.read_o, 1'b0);
      check("rd_after_line_o", bus.line_o, line_model);
   endtask

   task automatic run_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                            input bit both, input bit rand_gaps);
      int guard;
      bit r;
      for (int k = 0; k < NBEATS; k++) exp_q.push_back(line[k*BURST_W +: BURST_W]);
      bus.line_i    = line;
      bus.address_i = addr;
      bus.write_i   = 1'b1;
      bus.read_i    = both;
      bus.resp_i    = 1'b0;
      step();
      bus.write_i   = 1'b0;
      bus.read_i    = 1'b0;
      bus.line_i    = {8{$urandom}};
      bus.address_i = $urandom;
      guard = 0;
      while (exp_q.size() > 0 && guard < GUARD) begin
         r = next_resp(rand_gaps);
         bus.resp_i  = r;
         bus.burst_i = rnd_beat();
         check("wr_write_o",   bus.write_o,   1'b1);
         check("wr_read_o",    bus.read_o,    1'b0);
         check("wr_resp_o",    bus.resp_o,    1'b0);
         check("wr_address_o", bus.address_o, aligned(addr));
         check("wr_burst_o",   bus.burst_o,   exp_q[0]);
         step();
         guard++;
         if (r) void'(exp_q.pop_front());
      end
      check("wr_done_resp_o",  bus.resp_o,  1'b1);
      check("wr_done_write_o", bus.write_o, 1'b0);
      check("wr_done_line_o",  bus.line_o,  line_model);
      step();
      check("wr_after_resp_o", bus.resp_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [LINE_W-1:0] wline;
      rst_n         = 1'b0;
      bus.line_i    = '0;
      bus.address_i = '0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;
      line_model    = '0;
      step();
      step();
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_quiet("idle");

      // Contiguous read of 0x1234: four beats, resp_o in the sixth cycle.
      beat_q = {64'h1111, 64'h2222, 64'h3333, 64'h4444};
      run_read(32'h0000_1234, 1'b0, 1'b0);

      // Write 0x8000_003F, line AAAA..DDDD from beat3 down to beat0.
      wline = {{4{16'hAAAA}}, {4{16'hBBBB}}, {4{16'hCCCC}}, {4{16'hDDDD}}};
      run_write(32'h8000_003F, wline, 1'b0, 1'b0);

      // Read with resp_i gaps 1,0,0,1,1,0,1.
      beat_q = {64'h1111, 64'h2222, 64'h3333, 64'h4444};
      pat_q  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      run_read(32'h0000_1234, 1'b0, 1'b0);

      // read_i and write_i together: the write wins.
      run_write(32'h0000_4567, {8{$urandom}}, 1'b1, 1'b1);

      // read_i held across DONE: the next burst follows directly.
      for (int k = 0; k < NBEATS; k++) beat_q.push_back(rnd_beat());
      run_read(32'h0000_2000, 1'b1, 1'b0);
      for (int k = 0; k < NBEATS; k++) beat_q.push_back(rnd_beat());
      run_read(32'h0000_2040, 1'b0, 1'b1);

      // resp_i strobes in IDLE change nothing.
      for (int i = 0; i < 3; i++) begin
         bus.resp_i  = 1'b1;
         bus.burst_i = rnd_beat();
         step();
         check_quiet("idle_resp");
         check("idle_resp_state",  state,       ST_IDLE);
         check("idle_resp_line_o", bus.line_o,  line_model);
      end
      bus.resp_i = 1'b0;

      // Reset after two read beats abandons the burst.
      bus.address_i = 32'h0000_3000;
      bus.read_i    = 1'b1;
      step();
      bus.read_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.resp_i  = 1'b1;
         bus.burst_i = rnd_beat();
         step();
      end
      bus.resp_i = 1'b0;
      rst_n      = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      line_model = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_quiet("post_reset");
      check("post_reset_line_o", bus.line_o, line_model);
      for (int k = 0; k < NBEATS; k++) beat_q.push_back(rnd_beat());
      run_read(32'h0000_3008, 1'b0, 1'b0);

      // Randomized mix of reads and writes with random stalls.
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k < NBEATS; k++) beat_q.push_back(rnd_beat());
            run_read($urandom, 1'b0, 1'b1);
         end else begin
            run_write($urandom, {8{$urandom}}, 1'(($urandom_range(0, 1))), 1'b1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
